// File: rtl/tile_spawner_if.sv
// Tile spawner request/result bundle.
//   req   : spawn request (master -> slave)
//   board : flattened N*N cells of CW bits, cell i at [i*CW +: CW]
//   busy  : slave is working on a request
//   done  : one-cycle result strobe
//   idx   : chosen cell index
//   code  : code to write into the chosen cell (1 or 2; 0 when full)
//   full  : board had no empty cell
interface tile_spawner_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 4
);
    localparam int unsigned CELLS = N * N;
    localparam int unsigned IW    = $clog2(CELLS);

    logic                  req;
    logic [CELLS*CW-1:0]   board;
    logic                  busy;
    logic                  done;
    logic [IW-1:0]         idx;
    logic [CW-1:0]         code;
    logic                  full;

    modport master (output req, board, input busy, done, idx, code, full);
    modport slave  (input req, board, output busy, done, idx, code, full);
endinterface

// File: rtl/tile_spawner.sv
// Picks a random empty cell of a 2048-style board and the tile code to place.
// A free-running 16-bit Galois LFSR drives both the 2-vs-4 choice and the
// random probes; after MAX_TRIES misses a linear scan guarantees completion.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : tile_spawner_if.slave (req/board in; busy/done/idx/code/full out)
module tile_spawner #(
    parameter int unsigned N         = 4,
    parameter int unsigned CW        = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [7:0]  P4_THRESH = 8'd26,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic           clk,
    input  logic           rst,
    tile_spawner_if.slave  bus
);
    localparam int unsigned CELLS = N * N;
    localparam int unsigned IW    = $clog2(CELLS);
    localparam int unsigned TW    = $clog2(MAX_TRIES + 1);
    localparam int unsigned BW    = CELLS * CW;
    // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
    localparam logic [15:0] TAPS  = 16'hB400;

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_SCAN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [TW-1:0]   try_q, try_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   snap_q, snap_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   code_q, code_d;
    logic            full_q, full_d;
    logic            busy_q, done_q;

    logic [CW-1:0]   snap_cell [CELLS];
    logic            any_empty;
    logic [IW-1:0]   cand;

    // LFSR advances every cycle regardless of FSM state
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    end

    // Unpack the snapshot and look for any empty cell on the live board
    always_comb begin
        any_empty = 1'b0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            snap_cell[i] = snap_q[i*CW +: CW];
            if (bus.board[i*CW +: CW] == '0) begin
                any_empty = 1'b1;
            end
        end
    end

    assign cand = lfsr_q[IW-1:0];

    // Next-state and result logic
    always_comb begin
        state_d = state_q;
        try_d   = try_q;
        ptr_d   = ptr_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        code_d  = code_q;
        full_d  = full_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (any_empty) begin
                        snap_d  = bus.board;
                        code_d  = (lfsr_q[15:8] < P4_THRESH) ? CW'(2) : CW'(1);
                        full_d  = 1'b0;
                        try_d   = '0;
                        state_d = S_PROBE;
                    end else begin
                        full_d  = 1'b1;
                        idx_d   = '0;
                        code_d  = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_PROBE: begin
                if (snap_cell[cand] == '0) begin
                    idx_d   = cand;
                    state_d = S_DONE;
                end else begin
                    try_d = TW'(try_q + TW'(1));
                    // Last allowed miss: fall back to a scan just past it
                    if (try_q == TW'(MAX_TRIES - 1)) begin
                        ptr_d   = IW'(cand + IW'(1));
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (snap_cell[ptr_q] == '0) begin
                    idx_d   = ptr_q;
                    state_d = S_DONE;
                end else begin
                    ptr_d = IW'(ptr_q + IW'(1));
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; busy/done track the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            try_q   <= '0;
            ptr_q   <= '0;
            snap_q  <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            try_q   <= try_d;
            ptr_q   <= ptr_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            full_q  <= full_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.idx  = idx_q;
    assign bus.code = code_q;
    assign bus.full = full_q;
endmodule

// File: tb/tb_tile_spawner.sv
// Self-checking bench for tile_spawner: three instances (default, MAX_TRIES=2
// with P4_THRESH=255, P4_THRESH=0) against a transaction-level predictor.
module tb_tile_spawner;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_spawner_if #(.N(4), .CW(4)) if_def ();
    tile_spawner_if #(.N(4), .CW(4)) if_mt2 ();
    tile_spawner_if #(.N(4), .CW(4)) if_p0 ();

    tile_spawner #(.N(4), .CW(4)) u_def (.clk(clk), .rst(rst), .bus(if_def.slave));
    tile_spawner #(.N(4), .CW(4), .MAX_TRIES(2), .P4_THRESH(8'd255))
        u_mt2 (.clk(clk), .rst(rst), .bus(if_mt2.slave));
    tile_spawner #(.N(4), .CW(4), .P4_THRESH(8'd0))
        u_p0 (.clk(clk), .rst(rst), .bus(if_p0.slave));

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference LFSR, reset and stepped like the spec says
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= step(m_lfsr);
    end

    typedef struct {
        logic       full;
        logic [3:0] idx;
        logic [3:0] code;
        int         lat;
    } pred_t;

    function automatic int max_of(input int sel);
        return (sel == 1) ? 2 : 8;
    endfunction

    function automatic int p4_of(input int sel);
        return (sel == 0) ? 26 : ((sel == 1) ? 255 : 0);
    endfunction

    // Predict result given the LFSR value seen in the capture cycle
    function automatic pred_t predict(input logic [63:0] brd, input logic [15:0] l, input int sel);
        pred_t p;
        logic [15:0] v;
        int c;
        bit found;
        p.full = 1'b1;
        p.idx = 4'd0;
        p.code = 4'd0;
        p.lat = 0;
        c = 0;
        for (int i = 0; i < 16; i++) if (brd[i*4 +: 4] == 4'd0) p.full = 1'b0;
        if (p.full) return p;
        p.code = (int'(l[15:8]) < p4_of(sel)) ? 4'd2 : 4'd1;
        v = step(l);
        found = 1'b0;
        for (int t = 0; t < max_of(sel); t++) begin
            if (!found) begin
                c = int'(v[3:0]);
                if (brd[c*4 +: 4] == 4'd0) begin
                    p.idx = v[3:0];
                    p.lat = t + 1;
                    found = 1'b1;
                end
                v = step(v);
            end
        end
        for (int s = 0; s < 16; s++) begin
            if (!found) begin
                int ptr;
                ptr = (c + 1 + s) % 16;
                if (brd[ptr*4 +: 4] == 4'd0) begin
                    p.idx = 4'(ptr);
                    p.lat = max_of(sel) + s + 1;
                    found = 1'b1;
                end
            end
        end
        return p;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, full, idx[3:0], code[3:0]}
    function automatic logic [10:0] outs(input int sel);
        case (sel)
            0:       return {if_def.busy, if_def.done, if_def.full, if_def.idx, if_def.code};
            1:       return {if_mt2.busy, if_mt2.done, if_mt2.full, if_mt2.idx, if_mt2.code};
            default: return {if_p0.busy, if_p0.done, if_p0.full, if_p0.idx, if_p0.code};
        endcase
    endfunction

    task automatic drive(input int sel, input logic r, input logic [63:0] b);
        case (sel)
            0:       begin if_def.req = r; if_def.board = b; end
            1:       begin if_mt2.req = r; if_mt2.board = b; end
            default: begin if_p0.req = r; if_p0.board = b; end
        endcase
    endtask

    task automatic wait_idle(input int sel);
        int n;
        logic [10:0] o;
        n = 0;
        o = outs(sel);
        while (o[10] && n < 40) begin
            tick();
            n++;
            o = outs(sel);
        end
        chk("idle reached", int'(o[10]), 0);
    endtask

    // One full transaction with model checks; returns idx, code, latency
    task automatic spawn(input int sel, input logic [63:0] brd, input string name,
                         output logic [3:0] gi, output logic [3:0] gc, output int gw);
        pred_t p;
        logic [10:0] o;
        drive(sel, 1'b1, brd);
        p = predict(brd, m_lfsr, sel);
        tick();
        // Live board changes after capture must not matter
        drive(sel, 1'b0, 64'h1111_1111_1111_1111);
        o = outs(sel);
        chk({name, " busy"}, int'(o[10]), 1);
        gw = 0;
        while (!o[9] && gw < 40) begin
            tick();
            gw++;
            o = outs(sel);
        end
        chk({name, " latency"}, gw, p.lat);
        chk({name, " idx"}, int'(o[7:4]), int'(p.idx));
        chk({name, " code"}, int'(o[3:0]), int'(p.code));
        chk({name, " full"}, int'(o[8]), int'(p.full));
        gi = o[7:4];
        gc = o[3:0];
        tick();
        o = outs(sel);
        chk({name, " done one cycle"}, int'(o[9]), 0);
        chk({name, " busy after"}, int'(o[10]), 0);
        chk({name, " result held"}, int'(o[7:0]), int'({gi, gc}));
    endtask

    typedef struct {
        logic [63:0] board;
        int          sel;
        int          idle_cyc;
        logic        exp_full;
        int          exp_idx;   // -1: position determined by the LFSR only
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [3:0]  gi, gc;
        int          gw;
        logic [10:0] o;
        logic [63:0] brd;
        pred_t       p;
        int          n;
        bit          found;

        vecs[0] = '{64'h0000_0000_0000_0000, 0, 0, 1'b0, -1};
        vecs[1] = '{64'h1111_1111_1111_1111, 0, 1, 1'b1, 0};
        vecs[2] = '{64'h1111_1111_1101_1111, 0, 2, 1'b0, 5};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 0, 3, 1'b0, 15};
        vecs[4] = '{64'hFEDC_BA98_7654_3210, 1, 0, 1'b0, 0};
        vecs[5] = '{64'h1010_1010_1010_1010, 2, 1, 1'b0, -1};
        vecs[6] = '{64'h2222_2222_2222_2222, 2, 0, 1'b1, 0};
        vecs[7] = '{64'h2200_0000_0000_0022, 1, 5, 1'b0, -1};

        rst = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 64'h0);
        #12;
        for (int s = 0; s < 3; s++) begin
            o = outs(s);
            chk("reset outputs", int'(o), 0);
        end
        tick();
        rst = 1'b0;

        // Request on the very first edge after reset: lfsr=SEED at capture
        spawn(0, 64'h0, "first after reset", gi, gc, gw);
        chk("first idx hand", int'(gi), 0);
        chk("first code hand", int'(gc), 1);
        chk("first latency hand", gw, 1);

        for (int v = 0; v < 8; v++) begin
            for (int c = 0; c < vecs[v].idle_cyc; c++) tick();
            spawn(vecs[v].sel, vecs[v].board, $sformatf("vec%0d", v), gi, gc, gw);
            o = outs(vecs[v].sel);
            chk($sformatf("vec%0d full hand", v), int'(o[8]), int'(vecs[v].exp_full));
            if (vecs[v].exp_idx >= 0) chk($sformatf("vec%0d idx hand", v), int'(gi), vecs[v].exp_idx);
            if (vecs[v].exp_full) begin
                chk($sformatf("vec%0d code hand", v), int'(gc), 0);
                chk($sformatf("vec%0d full latency", v), gw, 0);
            end
            if (vecs[v].sel == 2) chk($sformatf("vec%0d p4=0 code", v), int'(gc), vecs[v].exp_full ? 0 : 1);
        end

        // Only cell 9 empty, MAX_TRIES=2: start when both probes are known to miss
        brd = 64'h1111_1101_1111_1111;
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            p = predict(brd, m_lfsr, 1);
            if (p.lat >= 3) found = 1'b1;
            else tick();
        end
        chk("scan window found", int'(found), 1);
        spawn(1, brd, "scan to 9", gi, gc, gw);
        chk("scan idx hand", int'(gi), 9);
        chk_range("scan latency bound", gw, 3, 19);

        // Reset while scanning
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            p = predict(brd, m_lfsr, 1);
            if (p.lat >= 3) found = 1'b1;
            else tick();
        end
        chk("scan window 2 found", int'(found), 1);
        drive(1, 1'b1, brd);
        tick();
        drive(1, 1'b0, brd);
        tick();
        tick();
        o = outs(1);
        chk("in scan busy", int'(o[10]), 1);
        chk("in scan done", int'(o[9]), 0);
        #2 rst = 1'b1;
        #1;
        o = outs(1);
        chk("mid-op reset busy", int'(o[10]), 0);
        chk("mid-op reset result", int'(o[8:0]), 0);
        tick();
        rst = 1'b0;
        spawn(1, 64'h0, "after reset", gi, gc, gw);
        chk("after reset idx hand", int'(gi), 0);
        chk("after reset code hand", int'(gc), 2);
        chk("after reset latency hand", gw, 1);

        // Held request for 100 cycles on a partly filled board
        begin
            int run, maxrun, pulses;
            logic prevdone;
            brd = 64'h1203_0405_0060_7080;
            run = 0; maxrun = 0; pulses = 0; prevdone = 1'b0;
            drive(0, 1'b1, brd);
            for (int t = 0; t < 100; t++) begin
                tick();
                o = outs(0);
                if (o[9]) begin
                    pulses++;
                    chk("held idx empty", int'(brd[int'(o[7:4])*4 +: 4]), 0);
                    chk("held single pulse", int'(prevdone), 0);
                end
                prevdone = o[9];
                if (o[10]) run++;
                else run = 0;
                if (run > maxrun) maxrun = run;
            end
            drive(0, 1'b0, brd);
            chk_range("held busy run", maxrun, 1, 25);
            chk_range("held pulses", pulses, 3, 34);
            wait_idle(0);
        end

        // 1000 spawns per instance with held request on an empty board
        begin
            logic [15:0] cap [3];
            int cnt [3];
            int two;
            two = 0;
            for (int s = 0; s < 3; s++) begin
                drive(s, 1'b1, 64'h0);
                cap[s] = m_lfsr;
                cnt[s] = 0;
            end
            n = 0;
            while (cnt[0] < 1000 && n < 4000) begin
                tick();
                n++;
                for (int s = 0; s < 3; s++) begin
                    o = outs(s);
                    if (o[9]) begin
                        cnt[s]++;
                        chk($sformatf("stream%0d code", s), int'(o[3:0]),
                            (int'(cap[s][15:8]) < p4_of(s)) ? 2 : 1);
                        if (s == 0 && o[3:0] == 4'd2) two++;
                    end
                    if (!o[10]) cap[s] = m_lfsr;
                end
            end
            for (int s = 0; s < 3; s++) drive(s, 1'b0, 64'h0);
            chk("stream count", cnt[0], 1000);
            chk_range("code2 share of 1000", two, 60, 160);
            for (int s = 0; s < 3; s++) wait_idle(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_spawner.md
TILE_SPAWNER -- requirements
Module: tile_spawner

Interface
REQ-001 Parameter N, default 4: board side; board has N*N cells; N SHALL be 2, 4 or 8.
REQ-002 Parameter CW, default 4: cell code width; code 0 = empty, code k = tile value 2^k.
REQ-003 Parameter SEED, default 16'hACE1: LFSR reset value; SEED SHALL be nonzero.
REQ-004 Parameter P4_THRESH, default 8'd26: threshold for spawning a 4 (about 10%).
REQ-005 Parameter MAX_TRIES, default 8: random probes allowed before the linear scan starts.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 req  in  1  spawn request; sampled only in IDLE.
REQ-009 board  in  N*N*CW  flattened cells; cell i occupies bits [i*CW +: CW].
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse marking a result.
REQ-012 idx  out  log2(N*N)  chosen cell index; valid when done=1.
REQ-013 code  out  CW  code to write into the chosen cell: 1 or 2.
REQ-014 full  out  1  high with done when the board has no empty cell.

Function
REQ-015 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, steps every cycle that rst is low, independent of the FSM state.
REQ-016 FSM states: IDLE, PROBE, SCAN, DONE.
REQ-017 IDLE with req=1 and at least one board cell equal to 0: capture board into snapshot, capture code, set try counter to 0, go to PROBE.
REQ-018 Captured code = 2 if lfsr[15:8] < P4_THRESH, otherwise 1.
REQ-019 IDLE with req=1 and every cell nonzero: go to DONE with full=1, idx=0, code=0.
REQ-020 PROBE, each cycle:
  - candidate c = lfsr[log2(N*N)-1:0].
  - snapshot[c]==0: idx=c, go to DONE.
  - Otherwise increment the try counter.
  - When the counter reaches MAX_TRIES: scan pointer = c+1 mod N*N, go to SCAN.
REQ-021 SCAN: one cell per cycle, pointer wraps N*N-1 -> 0; the first empty cell sets idx=pointer and goes to DONE.
  - Termination is guaranteed because the snapshot contains at least one empty cell (REQ-017).
REQ-022 DONE: done=1 for exactly one cycle, then IDLE.
REQ-023 idx, code and full hold their values from DONE until the next capture.
REQ-024 Latency from req sampled at edge k:
  - first-probe hit: done high in the cycle after edge k+1.
  - full board: done high in the cycle after edge k.
  - worst case: 1 + MAX_TRIES + N*N cycles.
REQ-025 req while busy=1 is ignored and not queued.
REQ-026 req held high: a new request is accepted on the first IDLE cycle after DONE.
REQ-027 board changes after capture do not affect the result; only the snapshot is used.

Reset
REQ-028 Asserting rst, including mid-operation, immediately forces:
  - state=IDLE
  - lfsr=SEED
  - try counter=0
  - busy=0, done=0, idx=0, code=0, full=0
  - snapshot=0
REQ-029 After rst deasserts, the first LFSR step occurs on the first rising edge.

Verification
REQ-030 Board all zero, req pulse on the first edge after reset, N=4: done two cycles later; idx = lfsr[3:0] at the probe cycle; code=1 or 2 per REQ-018.
REQ-031 Board all cells 1, req: done one cycle later with full=1, idx=0, code=0, busy=0 after.
REQ-032 Only cell 9 empty, MAX_TRIES=2, LFSR forced to miss twice: SCAN reaches 9 with wrap if needed; idx=9; latency at most 1+2+16.
REQ-033 rst asserted while in SCAN: all outputs 0 and state IDLE immediately; the next req behaves as in REQ-030 from SEED.
REQ-034 req held high for 100 cycles, empty board: done pulses periodically, busy never sticks, and every idx is a cell that was empty.
REQ-035 P4_THRESH=0: code is always 1; P4_THRESH=255: code=2 unless lfsr[15:8]=8'hFF; over 1000 spawns with the default, the count of code=2 is within 6-16%.
